// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state instruction sequencer for a register-file/ALU datapath.
//
// An instruction is accepted in IDLE on the valid/ready handshake and decoded on that
// same edge. All operand outputs are registered at that edge, so they are stable from
// DECODE through WB. A legal instruction then walks DECODE -> EXEC -> WB -> IDLE, one
// cycle each. An unknown encoding goes DECODE -> IDLE with a one-cycle illegal pulse.
//
// Optional feature (compile-time macro CARRY_IN_EN):
//   defined   - ADDC/ADDCI are legal, and cin carries flags_in[0] sampled at accept.
//   undefined - ADDC/ADDCI decode as illegal, and cin is tied to 0.
//
// Ports:
//   clk            system clock, rising edge
//   Reset          asynchronous active-low reset
//   instr          instruction word: [15:12] opcode, [11:8] Rdest, [7:4] ext/imm-hi,
//                  [3:0] Rsrc/imm-lo
//   instr_valid    requester has an instruction
//   instr_ready    sequencer can accept (IDLE only)
//   flags_in       flag register contents; bit 0 is carry
//   A_Mux_input    ALU A operand register select
//   B_Mux_input    ALU B operand register select
//   Reg_Enable     write-destination register select
//   Reg_Write      write strobe qualifying Reg_Enable (WB)
//   Imm_mux_input  1 selects Immediate as ALU B operand
//   Immediate      extended 16-bit immediate
//   OP             ALU operation code
//   cin            ALU carry-in
//   Tri_Enable     result bus drive strobe (WB)
//   Flags_Enable   flag register capture strobe (EXEC)
//   done           one-cycle completion pulse (WB)
//   illegal        one-cycle rejection pulse (DECODE)

module alu_sequencer (
    input  logic        clk,
    input  logic        Reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [4:0]  flags_in,
    output logic [3:0]  A_Mux_input,
    output logic [3:0]  B_Mux_input,
    output logic [3:0]  Reg_Enable,
    output logic        Reg_Write,
    output logic        Imm_mux_input,
    output logic [15:0] Immediate,
    output logic [7:0]  OP,
    output logic        cin,
    output logic        Tri_Enable,
    output logic        Flags_Enable,
    output logic        done,
    output logic        illegal
);

`ifdef CARRY_IN_EN
    localparam bit CarryInEn = 1'b1;
`else
    localparam bit CarryInEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDecode = 2'd1,
        StExec   = 2'd2,
        StWb     = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Handshake
    logic accept;
    assign accept = (state_q == StIdle) && instr_valid;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word (used only on accept)
    // ------------------------------------------------------------------
    logic [3:0]  opcode, ext, rdest, rsrc;
    logic [7:0]  imm8;
    logic        dec_legal;
    logic        dec_imm_sel;
    logic [3:0]  dec_b;
    logic [15:0] dec_imm;
    logic [7:0]  dec_op;
    logic        dec_no_flags;  // MOV/MOVI/LUI leave flags untouched
    logic        dec_no_write;  // CMP/CMPI only update flags
    logic        dec_carry;     // ADDC/ADDCI

    assign opcode = instr[15:12];
    assign rdest  = instr[11:8];
    assign ext    = instr[7:4];
    assign rsrc   = instr[3:0];
    assign imm8   = instr[7:0];

    always_comb begin
        dec_legal    = 1'b0;
        dec_imm_sel  = 1'b0;
        dec_b        = 4'h0;
        dec_imm      = 16'h0000;
        dec_op       = 8'h00;
        dec_no_flags = 1'b0;
        dec_no_write = 1'b0;
        dec_carry    = 1'b0;

        if (opcode == 4'h0) begin
            // R-type: operation selected by ext
            case (ext)
                4'h1, 4'h2, 4'h3, 4'h5, 4'h9: dec_legal = 1'b1;
                4'h7: begin
                    dec_legal = CarryInEn;
                    dec_carry = 1'b1;
                end
                4'hB: begin
                    dec_legal    = 1'b1;
                    dec_no_write = 1'b1;
                end
                4'hD: begin
                    dec_legal    = 1'b1;
                    dec_no_flags = 1'b1;
                end
                default: dec_legal = 1'b0;
            endcase
            if (dec_legal) begin
                dec_op = {4'h0, ext};
                dec_b  = rsrc;
            end
        end else begin
            // I-type: operation selected by opcode, B comes from Immediate
            case (opcode)
                4'h1, 4'h2, 4'h3: begin
                    dec_legal = 1'b1;
                    dec_imm   = {8'h00, imm8};
                end
                4'h5, 4'h9: begin
                    dec_legal = 1'b1;
                    dec_imm   = {{8{imm8[7]}}, imm8};
                end
                4'h7: begin
                    dec_legal = CarryInEn;
                    dec_carry = 1'b1;
                    dec_imm   = {{8{imm8[7]}}, imm8};
                end
                4'hB: begin
                    dec_legal    = 1'b1;
                    dec_no_write = 1'b1;
                    dec_imm      = {{8{imm8[7]}}, imm8};
                end
                4'hD: begin
                    dec_legal    = 1'b1;
                    dec_no_flags = 1'b1;
                    dec_imm      = {{8{imm8[7]}}, imm8};
                end
                4'hF: begin
                    dec_legal    = 1'b1;
                    dec_no_flags = 1'b1;
                    dec_imm      = {imm8, 8'h00};
                end
                default: dec_legal = 1'b0;
            endcase
            if (dec_legal) begin
                dec_op      = {opcode, 4'h0};
                dec_imm_sel = 1'b1;
            end else begin
                dec_imm = 16'h0000;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand registers: loaded on accept, held until the next accept.
    // An illegal word loads all-zero operands.
    // ------------------------------------------------------------------
    logic        legal_q;
    logic        no_flags_q;
    logic        no_write_q;
    logic [3:0]  a_sel_q;
    logic [3:0]  b_sel_q;
    logic [3:0]  reg_en_q;
    logic        imm_sel_q;
    logic [15:0] imm_q;
    logic [7:0]  op_q;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            legal_q    <= 1'b0;
            no_flags_q <= 1'b0;
            no_write_q <= 1'b0;
            a_sel_q    <= 4'h0;
            b_sel_q    <= 4'h0;
            reg_en_q   <= 4'h0;
            imm_sel_q  <= 1'b0;
            imm_q      <= 16'h0000;
            op_q       <= 8'h00;
        end else if (accept) begin
            legal_q    <= dec_legal;
            no_flags_q <= dec_no_flags;
            no_write_q <= dec_no_write;
            a_sel_q    <= dec_legal ? rdest : 4'h0;
            b_sel_q    <= dec_b;
            reg_en_q   <= dec_legal ? rdest : 4'h0;
            imm_sel_q  <= dec_imm_sel;
            imm_q      <= dec_imm;
            op_q       <= dec_op;
        end
    end

`ifdef CARRY_IN_EN
    logic cin_q;
    logic unused_flags;
    assign unused_flags = ^flags_in[4:1];

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cin_q <= 1'b0;
        end else if (accept) begin
            cin_q <= dec_legal && dec_carry && flags_in[0];
        end
    end
    assign cin = cin_q;
`else
    logic unused_flags;
    assign unused_flags = ^{flags_in, dec_carry};
    assign cin = 1'b0;
`endif

    assign A_Mux_input   = a_sel_q;
    assign B_Mux_input   = b_sel_q;
    assign Reg_Enable    = reg_en_q;
    assign Imm_mux_input = imm_sel_q;
    assign Immediate     = imm_q;
    assign OP            = op_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = StDecode;
            StDecode: state_d = legal_q ? StExec : StIdle;
            StExec:   state_d = StWb;
            StWb:     state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM: strobes, all decoded from state so reset clears them at once
    always_comb begin
        instr_ready  = 1'b0;
        illegal      = 1'b0;
        Flags_Enable = 1'b0;
        Tri_Enable   = 1'b0;
        Reg_Write    = 1'b0;
        done         = 1'b0;
        case (state_q)
            StIdle:   instr_ready = 1'b1;
            StDecode: illegal = !legal_q;
            StExec:   Flags_Enable = !no_flags_q;
            StWb: begin
                Tri_Enable = !no_write_q;
                Reg_Write  = !no_write_q;
                done       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic        clk;
    logic        Reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  flags_in;
    logic [3:0]  A_Mux_input;
    logic [3:0]  B_Mux_input;
    logic [3:0]  Reg_Enable;
    logic        Reg_Write;
    logic        Imm_mux_input;
    logic [15:0] Immediate;
    logic [7:0]  OP;
    logic        cin;
    logic        Tri_Enable;
    logic        Flags_Enable;
    logic        done;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_sequencer dut (
        .clk           (clk),
        .Reset         (Reset),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .flags_in      (flags_in),
        .A_Mux_input   (A_Mux_input),
        .B_Mux_input   (B_Mux_input),
        .Reg_Enable    (Reg_Enable),
        .Reg_Write     (Reg_Write),
        .Imm_mux_input (Imm_mux_input),
        .Immediate     (Immediate),
        .OP            (OP),
        .cin           (cin),
        .Tri_Enable    (Tri_Enable),
        .Flags_Enable  (Flags_Enable),
        .done          (done),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a word in IDLE; returns in cycle T1 (DECODE) with valid dropped
    task automatic issue(input logic [15:0] w);
        instr       = w;
        instr_valid = 1'b1;
        next_cycle();
        instr_valid = 1'b0;
    endtask

    // Strobe pattern of one full legal instruction, starting in T1
    task automatic walk(input string tag, input logic fe, input logic wr);
        chk({tag, " T1 flags"}, Flags_Enable, 1'b0);
        chk({tag, " T1 ready"}, instr_ready, 1'b0);
        next_cycle();
        chk({tag, " T2 flags"}, Flags_Enable, fe);
        chk({tag, " T2 write"}, Reg_Write, 1'b0);
        next_cycle();
        chk({tag, " T3 flags"}, Flags_Enable, 1'b0);
        chk({tag, " T3 write"}, Reg_Write, wr);
        chk({tag, " T3 tri"}, Tri_Enable, wr);
        chk({tag, " T3 done"}, done, 1'b1);
        next_cycle();
        chk({tag, " T4 ready"}, instr_ready, 1'b1);
        chk({tag, " T4 done"}, done, 1'b0);
    endtask

    initial begin
        Reset       = 1'b0;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        flags_in    = 5'b00000;

        // Reset state
        #2;
        chk("rst ready", instr_ready, 1'b1);
        chk("rst write", Reg_Write, 1'b0);
        chk("rst op", OP, 16'h0000);
        chk("rst imm", Immediate, 16'h0000);
        chk("rst done", done, 1'b0);
        chk("rst illegal", illegal, 1'b0);
        #10;
        Reset = 1'b1;

        // ADD r3,r5 with valid held; word changes mid-flight must be ignored
        instr       = 16'h0355;
        instr_valid = 1'b1;
        next_cycle();
        chk("add T1 ready", instr_ready, 1'b0);
        chk("add T1 flags", Flags_Enable, 1'b0);
        chk("add T1 dest", Reg_Enable, 16'h3);
        chk("add T1 a", A_Mux_input, 16'h3);
        chk("add T1 b", B_Mux_input, 16'h5);
        chk("add T1 op", OP, 16'h05);
        chk("add T1 immsel", Imm_mux_input, 1'b0);
        chk("add T1 cin", cin, 1'b0);
        instr = 16'h12FD;
        next_cycle();
        chk("add T2 flags", Flags_Enable, 1'b1);
        chk("add T2 write", Reg_Write, 1'b0);
        chk("add T2 op", OP, 16'h05);
        next_cycle();
        chk("add T3 write", Reg_Write, 1'b1);
        chk("add T3 tri", Tri_Enable, 1'b1);
        chk("add T3 done", done, 1'b1);
        chk("add T3 dest", Reg_Enable, 16'h3);
        chk("add T3 op", OP, 16'h05);
        chk("add T3 b", B_Mux_input, 16'h5);
        instr_valid = 1'b0;
        next_cycle();
        chk("add T4 ready", instr_ready, 1'b1);
        chk("add T4 done", done, 1'b0);

        // ADDI r2,#-3
        issue(16'h52FD);
        chk("addi imm", Immediate, 16'hFFFD);
        chk("addi immsel", Imm_mux_input, 1'b1);
        chk("addi op", OP, 16'h50);
        chk("addi dest", Reg_Enable, 16'h2);
        chk("addi a", A_Mux_input, 16'h2);
        walk("addi", 1'b1, 1'b1);

        // ANDI r2,#FD (zero-extended)
        issue(16'h12FD);
        chk("andi imm", Immediate, 16'h00FD);
        chk("andi op", OP, 16'h10);
        walk("andi", 1'b1, 1'b1);

        // LUI r1,#AB
        issue(16'hF1AB);
        chk("lui imm", Immediate, 16'hAB00);
        chk("lui op", OP, 16'hF0);
        chk("lui dest", Reg_Enable, 16'h1);
        walk("lui", 1'b0, 1'b1);

        // MOV r1,r2
        issue(16'h01D2);
        chk("mov op", OP, 16'h0D);
        chk("mov b", B_Mux_input, 16'h2);
        walk("mov", 1'b0, 1'b1);

        // CMP r4,r6
        issue(16'h04B6);
        chk("cmp op", OP, 16'h0B);
        chk("cmp b", B_Mux_input, 16'h6);
        chk("cmp T1 tri", Tri_Enable, 1'b0);
        walk("cmp", 1'b1, 1'b0);

        // CMPI r4,#80 (sign-extended)
        issue(16'hB480);
        chk("cmpi imm", Immediate, 16'hFF80);
        walk("cmpi", 1'b1, 1'b0);

        // Opcode 0100: illegal
        issue(16'h4123);
        chk("ill4 pulse", illegal, 1'b1);
        chk("ill4 flags", Flags_Enable, 1'b0);
        chk("ill4 write", Reg_Write, 1'b0);
        chk("ill4 done", done, 1'b0);
        next_cycle();
        chk("ill4 pulse end", illegal, 1'b0);
        chk("ill4 ready", instr_ready, 1'b1);
        chk("ill4 flags2", Flags_Enable, 1'b0);

        // R-type with bad ext
        issue(16'h0146);
        chk("illx pulse", illegal, 1'b1);
        next_cycle();
        chk("illx ready", instr_ready, 1'b1);

`ifdef CARRY_IN_EN
        // ADDC r1,r2 with carry set
        flags_in = 5'b00001;
        issue(16'h0172);
        flags_in = 5'b00000;
        chk("addc T1 cin", cin, 1'b1);
        chk("addc T1 op", OP, 16'h07);
        chk("addc T1 illegal", illegal, 1'b0);
        next_cycle();
        chk("addc T2 cin", cin, 1'b1);
        chk("addc T2 flags", Flags_Enable, 1'b1);
        next_cycle();
        chk("addc T3 cin", cin, 1'b1);
        chk("addc T3 done", done, 1'b1);
        next_cycle();
        // ADD with carry set: cin stays 0
        flags_in = 5'b00001;
        issue(16'h0355);
        chk("add cin", cin, 1'b0);
        flags_in = 5'b00000;
        next_cycle();
        next_cycle();
        next_cycle();
`else
        // ADDCI / ADDC are illegal without carry-in support
        issue(16'h7101);
        chk("addci illegal", illegal, 1'b1);
        chk("addci cin", cin, 1'b0);
        next_cycle();
        chk("addci ready", instr_ready, 1'b1);
        flags_in = 5'b00001;
        issue(16'h0172);
        chk("addc illegal", illegal, 1'b1);
        chk("addc cin", cin, 1'b0);
        flags_in = 5'b00000;
        next_cycle();
        chk("addc ready", instr_ready, 1'b1);
`endif

        // Reset asserted during EXEC aborts the instruction
        issue(16'h0355);
        next_cycle();
        chk("abort pre flags", Flags_Enable, 1'b1);
        Reset = 1'b0;
        #1;
        chk("abort flags", Flags_Enable, 1'b0);
        chk("abort op", OP, 16'h00);
        chk("abort dest", Reg_Enable, 16'h0);
        chk("abort ready", instr_ready, 1'b1);
        #2;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("abort post write", Reg_Write, 1'b0);
            chk("abort post done", done, 1'b0);
            chk("abort post flags", Flags_Enable, 1'b0);
            chk("abort post ready", instr_ready, 1'b1);
        end

        // Normal operation resumes
        issue(16'h0355);
        chk("resume op", OP, 16'h05);
        walk("resume", 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
